// File: rtl/arm_ctrl_pkg.sv
// Shared encodings for the multicycle ARM-subset control unit.
// Latency: n/a (constants and a pure decode function only).
// Backpressure: n/a.
package arm_ctrl_pkg;

    // FSM state encodings; the numeric values are visible on state_o.
    typedef enum logic [3:0] {
        S_FETCH  = 4'd0,
        S_DECODE = 4'd1,
        S_MEMADR = 4'd2,
        S_MEMRD  = 4'd3,
        S_MEMWB  = 4'd4,
        S_MEMWR  = 4'd5,
        S_EXECR  = 4'd6,
        S_EXECI  = 4'd7,
        S_ALUWB  = 4'd8,
        S_BRANCH = 4'd9
    } state_t;

    // Instr[27:26] op field.
    localparam logic [1:0] OP_DP  = 2'b00;
    localparam logic [1:0] OP_MEM = 2'b01;
    localparam logic [1:0] OP_BR  = 2'b10;
    localparam logic [1:0] OP_ILL = 2'b11;

    // alu_control codes.
    localparam logic [1:0] ALU_ADD = 2'b00;
    localparam logic [1:0] ALU_SUB = 2'b01;
    localparam logic [1:0] ALU_AND = 2'b10;
    localparam logic [1:0] ALU_ORR = 2'b11;

    // result_src codes.
    localparam logic [1:0] RES_ALUOUT    = 2'b00;
    localparam logic [1:0] RES_DATA      = 2'b01;
    localparam logic [1:0] RES_ALURESULT = 2'b10;

    // alu_src_b codes.
    localparam logic [1:0] SRCB_RD2  = 2'b00;
    localparam logic [1:0] SRCB_IMM  = 2'b01;
    localparam logic [1:0] SRCB_FOUR = 2'b10;

    // Data-processing cmd field (Instr[24:21]).
    localparam logic [3:0] CMD_AND = 4'b0000;
    localparam logic [3:0] CMD_SUB = 4'b0010;
    localparam logic [3:0] CMD_ADD = 4'b0100;
    localparam logic [3:0] CMD_ORR = 4'b1100;

    // ARM condition codes.
    localparam logic [3:0] COND_EQ = 4'h0;
    localparam logic [3:0] COND_NE = 4'h1;
    localparam logic [3:0] COND_CS = 4'h2;
    localparam logic [3:0] COND_CC = 4'h3;
    localparam logic [3:0] COND_MI = 4'h4;
    localparam logic [3:0] COND_PL = 4'h5;
    localparam logic [3:0] COND_VS = 4'h6;
    localparam logic [3:0] COND_VC = 4'h7;
    localparam logic [3:0] COND_HI = 4'h8;
    localparam logic [3:0] COND_LS = 4'h9;
    localparam logic [3:0] COND_GE = 4'hA;
    localparam logic [3:0] COND_LT = 4'hB;
    localparam logic [3:0] COND_GT = 4'hC;
    localparam logic [3:0] COND_LE = 4'hD;
    localparam logic [3:0] COND_AL = 4'hE;

    typedef struct packed {
        logic       supported;   // cmd is one of ADD/SUB/AND/ORR
        logic       arith;       // ADD/SUB: C and V are meaningful
        logic [1:0] alu_control;
    } cmd_dec_t;

    function automatic cmd_dec_t cmd_decode(input logic [3:0] cmd);
        cmd_dec_t d;
        d = '{supported: 1'b0, arith: 1'b0, alu_control: ALU_ADD};
        case (cmd)
            CMD_ADD: d = '{supported: 1'b1, arith: 1'b1, alu_control: ALU_ADD};
            CMD_SUB: d = '{supported: 1'b1, arith: 1'b1, alu_control: ALU_SUB};
            CMD_AND: d = '{supported: 1'b1, arith: 1'b0, alu_control: ALU_AND};
            CMD_ORR: d = '{supported: 1'b1, arith: 1'b0, alu_control: ALU_ORR};
            default: d = '{supported: 1'b0, arith: 1'b0, alu_control: ALU_ADD};
        endcase
        return d;
    endfunction

endpackage

// File: rtl/cond_unit.sv
// NZCV flags register, condition evaluation and the latched per-instruction condition result.
// Latency: cond_ex is combinational; flags and cond_ex_q update on the next rising edge.
// Backpressure: none; loads happen whenever the enables are high.
module cond_unit
    import arm_ctrl_pkg::*;
#(
    parameter logic [3:0] FLAG_RESET = 4'b0000
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic [3:0] cond,
    input  logic [3:0] alu_flags,
    input  logic       flag_wr_nz,
    input  logic       flag_wr_cv,
    input  logic       cond_ex_load,
    output logic       cond_ex,
    output logic       cond_ex_q,
    output logic [3:0] flags
);

    logic [3:0] flags_q;
    logic       n_f, z_f, c_f, v_f;

    assign flags = flags_q;
    assign {n_f, z_f, c_f, v_f} = flags_q;

    // Flags register: N/Z and C/V halves have independent load enables.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            flags_q <= FLAG_RESET;
        end else begin
            if (flag_wr_nz) flags_q[3:2] <= alu_flags[3:2];
            if (flag_wr_cv) flags_q[1:0] <= alu_flags[1:0];
        end
    end

    // Evaluate the instruction's condition against the current flags.
    always_comb begin
        cond_ex = 1'b0;
        case (cond)
            COND_EQ: cond_ex = z_f;
            COND_NE: cond_ex = ~z_f;
            COND_CS: cond_ex = c_f;
            COND_CC: cond_ex = ~c_f;
            COND_MI: cond_ex = n_f;
            COND_PL: cond_ex = ~n_f;
            COND_VS: cond_ex = v_f;
            COND_VC: cond_ex = ~v_f;
            COND_HI: cond_ex = c_f & ~z_f;
            COND_LS: cond_ex = ~c_f | z_f;
            COND_GE: cond_ex = (n_f == v_f);
            COND_LT: cond_ex = (n_f != v_f);
            COND_GT: cond_ex = ~z_f & (n_f == v_f);
            COND_LE: cond_ex = z_f | (n_f != v_f);
            COND_AL: cond_ex = 1'b1;
            default: cond_ex = 1'b0;  // 1111 never executes
        endcase
    end

    // Latch the condition result at the end of DECODE for the rest of the instruction.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cond_ex_q <= 1'b0;
        end else if (cond_ex_load) begin
            cond_ex_q <= cond_ex;
        end
    end

endmodule

// File: rtl/multicycle_ctrl.sv
// Multicycle ARM-subset control FSM: sequences fetch/decode/execute and drives datapath controls.
// Latency: DP 4, LDR 5, STR 4, B 3, illegal op 2 cycles per instruction.
// Backpressure: none; one state per cycle, write enables forced low while reset_n is low.
module multicycle_ctrl
    import arm_ctrl_pkg::*;
#(
    parameter logic [3:0] FLAG_RESET = 4'b0000
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic [3:0] cond,
    input  logic [1:0] op,
    input  logic [5:0] funct,
    input  logic [3:0] rd,
    input  logic [3:0] alu_flags,
    output logic       pc_write,
    output logic       adr_src,
    output logic       mem_write,
    output logic       ir_write,
    output logic       reg_write,
    output logic [1:0] result_src,
    output logic       alu_src_a,
    output logic [1:0] alu_src_b,
    output logic [1:0] imm_src,
    output logic [1:0] alu_control,
    output logic [3:0] state_o
);

    state_t   state, next_state;
    cmd_dec_t dec;
    logic     cond_ex, cond_ex_q;
    logic [3:0] flags;
    logic     cond_ex_load, flag_wr_nz, flag_wr_cv;
    logic     pc_write_c, mem_write_c, ir_write_c, reg_write_c;
    logic     wb_en;

    assign dec     = cmd_decode(funct[4:1]);
    assign imm_src = op;
    assign state_o = state;

    // Write enables are gated by reset so an in-flight write stops the instant reset asserts.
    assign pc_write  = pc_write_c  & reset_n;
    assign mem_write = mem_write_c & reset_n;
    assign ir_write  = ir_write_c  & reset_n;
    assign reg_write = reg_write_c & reset_n;

    cond_unit #(
        .FLAG_RESET (FLAG_RESET)
    ) u_cond (
        .clk          (clk),
        .reset_n      (reset_n),
        .cond         (cond),
        .alu_flags    (alu_flags),
        .flag_wr_nz   (flag_wr_nz),
        .flag_wr_cv   (flag_wr_cv),
        .cond_ex_load (cond_ex_load),
        .cond_ex      (cond_ex),
        .cond_ex_q    (cond_ex_q),
        .flags        (flags)
    );

    // Raw condition and flags are only probed for debug from the top.
    logic unused_dbg;
    assign unused_dbg = ^{cond_ex, flags};

    // State register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state <= S_FETCH;
        else          state <= next_state;
    end

    // Next-state and per-state control decode.
    always_comb begin
        next_state   = S_FETCH;
        pc_write_c   = 1'b0;
        adr_src      = 1'b0;
        mem_write_c  = 1'b0;
        ir_write_c   = 1'b0;
        reg_write_c  = 1'b0;
        result_src   = RES_ALUOUT;
        alu_src_a    = 1'b0;
        alu_src_b    = SRCB_RD2;
        alu_control  = ALU_ADD;
        cond_ex_load = 1'b0;
        flag_wr_nz   = 1'b0;
        flag_wr_cv   = 1'b0;
        wb_en        = 1'b0;
        case (state)
            S_FETCH: begin
                ir_write_c = 1'b1;
                alu_src_a  = 1'b1;
                alu_src_b  = SRCB_FOUR;
                result_src = RES_ALURESULT;
                pc_write_c = 1'b1;
                next_state = S_DECODE;
            end
            S_DECODE: begin
                alu_src_a    = 1'b1;
                alu_src_b    = SRCB_FOUR;
                result_src   = RES_ALURESULT;
                cond_ex_load = 1'b1;
                case (op)
                    OP_MEM:  next_state = S_MEMADR;
                    OP_DP:   next_state = funct[5] ? S_EXECI : S_EXECR;
                    OP_BR:   next_state = S_BRANCH;
                    default: next_state = S_FETCH;   // illegal op retires as a NOP
                endcase
            end
            S_MEMADR: begin
                alu_src_b  = SRCB_IMM;
                next_state = funct[0] ? S_MEMRD : S_MEMWR;
            end
            S_MEMRD: begin
                adr_src    = 1'b1;
                next_state = S_MEMWB;
            end
            S_MEMWB: begin
                result_src = RES_DATA;
                wb_en      = cond_ex_q;
            end
            S_MEMWR: begin
                adr_src     = 1'b1;
                mem_write_c = cond_ex_q;
            end
            S_EXECR, S_EXECI: begin
                alu_src_b   = (state == S_EXECI) ? SRCB_IMM : SRCB_RD2;
                alu_control = dec.alu_control;
                flag_wr_nz  = funct[0] & cond_ex_q & dec.supported;
                flag_wr_cv  = funct[0] & cond_ex_q & dec.supported & dec.arith;
                next_state  = S_ALUWB;
            end
            S_ALUWB: begin
                result_src = RES_ALUOUT;
                wb_en      = cond_ex_q & dec.supported;
            end
            S_BRANCH: begin
                alu_src_b  = SRCB_IMM;
                result_src = RES_ALURESULT;
                pc_write_c = cond_ex_q;
            end
            default: next_state = S_FETCH;
        endcase
        // A write-back to r15 is a PC load instead of a register file write.
        if (rd == 4'd15) pc_write_c  = pc_write_c | wb_en;
        else             reg_write_c = wb_en;
    end

endmodule

// File: tb/tb_multicycle_ctrl.sv
module tb_multicycle_ctrl;

    localparam logic [3:0] FLAG_RESET = 4'b0000;

    logic       clk = 1'b0;
    logic       reset_n;
    logic [3:0] cond;
    logic [1:0] op;
    logic [5:0] funct;
    logic [3:0] rd;
    logic [3:0] alu_flags;
    logic       pc_write, adr_src, mem_write, ir_write, reg_write, alu_src_a;
    logic [1:0] result_src, alu_src_b, imm_src, alu_control;
    logic [3:0] state_o;

    always #5 clk = ~clk;

    multicycle_ctrl #(.FLAG_RESET(FLAG_RESET)) dut (
        .clk(clk), .reset_n(reset_n), .cond(cond), .op(op), .funct(funct), .rd(rd),
        .alu_flags(alu_flags), .pc_write(pc_write), .adr_src(adr_src),
        .mem_write(mem_write), .ir_write(ir_write), .reg_write(reg_write),
        .result_src(result_src), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b),
        .imm_src(imm_src), .alu_control(alu_control), .state_o(state_o)
    );

    // One expected control vector per clock cycle.
    typedef struct packed {
        logic [3:0] st;
        logic       pcw, adr, memw, irw, regw;
        logic [1:0] res;
        logic       srca;
        logic [1:0] srcb, imm, aluc;
        logic [3:0] flg;
    } rec_t;

    rec_t       exp_q[$];
    int         n_checks = 0;
    int         n_fail   = 0;
    bit         mon_en   = 1'b0;
    logic [3:0] mflags;
    int         cyc_budget = 1 << 30;
    bit         abort_mode = 1'b0;

    // ARM condition rule: even codes test a predicate, odd codes its inverse; 14 always, 15 never.
    function automatic bit cond_holds(input logic [3:0] c, input logic [3:0] f);
        bit n, z, cc, v, base;
        n = f[3]; z = f[2]; cc = f[1]; v = f[0];
        case (c[3:1])
            3'd0: base = z;
            3'd1: base = cc;
            3'd2: base = n;
            3'd3: base = v;
            3'd4: base = cc && !z;
            3'd5: base = (n == v);
            3'd6: base = !z && (n == v);
            default: base = 1'b1;
        endcase
        if (c == 4'hF) return 1'b0;
        if (c == 4'hE) return 1'b1;
        return c[0] ? !base : base;
    endfunction

    task automatic check_reset(input string name);
        logic [8:0] act, req;
        act = {state_o, pc_write, mem_write, ir_write, reg_write, 1'b0};
        req = 9'd0;
        n_checks++;
        if (act !== req || dut.u_cond.flags !== FLAG_RESET) begin
            n_fail++;
            $display("FAIL %s: state=%0d pcw=%b memw=%b irw=%b regw=%b flags=%b, required state=0 enables=0 flags=%b",
                     name, state_o, pc_write, mem_write, ir_write, reg_write, dut.u_cond.flags, FLAG_RESET);
        end
    endtask

    // Issue one cycle: present alu_flags, queue its expected vector, advance to posedge+1.
    task automatic cyc(input rec_t r, input logic [3:0] af);
        if (cyc_budget == 0) return;
        cyc_budget--;
        alu_flags = af;
        exp_q.push_back(r);
        if (cyc_budget == 0 && abort_mode) begin
            @(negedge clk);
            #1;
            mon_en  = 1'b0;
            reset_n = 1'b0;
            #1 check_reset("reset_async_in_memwr");
            @(posedge clk);
            #1 check_reset("reset_held");
            @(posedge clk);
            #1;
        end else begin
            @(posedge clk);
            #1;
        end
    endtask

    // Reference model: one whole instruction, expressed as the cycle-by-cycle control pattern.
    task automatic run_instr(input logic [3:0] c, input logic [1:0] o, input logic [5:0] f,
                             input logic [3:0] r, input logic [3:0] exec_af);
        rec_t       base, x;
        bit         cex, sup, wr;
        logic [1:0] ac;
        cond = c; op = o; funct = f; rd = r;
        base = '0;
        base.imm = o;
        base.flg = mflags;
        x = base; x.st = 4'd0; x.irw = 1; x.srca = 1; x.srcb = 2'b10; x.res = 2'b10; x.pcw = 1;
        cyc(x, 4'($urandom));
        x = base; x.st = 4'd1; x.srca = 1; x.srcb = 2'b10; x.res = 2'b10;
        cyc(x, 4'($urandom));
        cex = cond_holds(c, mflags);
        case (o)
            2'b01: begin
                x = base; x.st = 4'd2; x.srcb = 2'b01;
                cyc(x, 4'($urandom));
                if (f[0]) begin
                    x = base; x.st = 4'd3; x.adr = 1;
                    cyc(x, 4'($urandom));
                    x = base; x.st = 4'd4; x.res = 2'b01;
                    if (r == 4'd15) x.pcw = cex; else x.regw = cex;
                    cyc(x, 4'($urandom));
                end else begin
                    x = base; x.st = 4'd5; x.adr = 1; x.memw = cex;
                    cyc(x, 4'($urandom));
                end
            end
            2'b00: begin
                case (f[4:1])
                    4'b0100: begin sup = 1; ac = 2'b00; end
                    4'b0010: begin sup = 1; ac = 2'b01; end
                    4'b0000: begin sup = 1; ac = 2'b10; end
                    4'b1100: begin sup = 1; ac = 2'b11; end
                    default: begin sup = 0; ac = 2'b00; end
                endcase
                x = base; x.st = f[5] ? 4'd7 : 4'd6; x.srcb = f[5] ? 2'b01 : 2'b00; x.aluc = ac;
                cyc(x, exec_af);
                if (f[0] && cex && sup) begin
                    mflags[3:2] = exec_af[3:2];
                    if (f[4:1] == 4'b0100 || f[4:1] == 4'b0010) mflags[1:0] = exec_af[1:0];
                end
                base.flg = mflags;
                wr = cex && sup;
                x = base; x.st = 4'd8; x.res = 2'b00;
                if (r == 4'd15) x.pcw = wr; else x.regw = wr;
                cyc(x, 4'($urandom));
            end
            2'b10: begin
                x = base; x.st = 4'd9; x.srcb = 2'b01; x.res = 2'b10; x.pcw = cex;
                cyc(x, 4'($urandom));
            end
            default: ;
        endcase
    endtask

    // Monitor: every cycle the DUT presents a control vector; compare against the scoreboard.
    always @(negedge clk) begin
        rec_t a, e;
        if (mon_en) begin
            a = {state_o, pc_write, adr_src, mem_write, ir_write, reg_write, result_src,
                 alu_src_a, alu_src_b, imm_src, alu_control, dut.u_cond.flags};
            n_checks++;
            if (exp_q.size() == 0) begin
                n_fail++;
                $display("FAIL ctrl_underflow: got state=%0d with no expected entry", state_o);
            end else begin
                e = exp_q.pop_front();
                if (a !== e) begin
                    n_fail++;
                    $display("FAIL ctrl_vec t=%0t: got st=%0d pcw=%b adr=%b memw=%b irw=%b regw=%b res=%b a=%b b=%b imm=%b aluc=%b flg=%b; required st=%0d pcw=%b adr=%b memw=%b irw=%b regw=%b res=%b a=%b b=%b imm=%b aluc=%b flg=%b",
                             $time, a.st, a.pcw, a.adr, a.memw, a.irw, a.regw, a.res, a.srca, a.srcb, a.imm, a.aluc, a.flg,
                             e.st, e.pcw, e.adr, e.memw, e.irw, e.regw, e.res, e.srca, e.srcb, e.imm, e.aluc, e.flg);
                end
            end
        end
    end

    task automatic run_random(input int count);
        logic [3:0] c, r;
        for (int i = 0; i < count; i++) begin
            c = ($urandom_range(0, 3) == 0) ? 4'hE : 4'($urandom);
            r = ($urandom_range(0, 3) == 0) ? 4'd15 : 4'($urandom);
            run_instr(c, 2'($urandom), 6'($urandom), r, 4'($urandom));
        end
    endtask

    initial begin
        reset_n = 1'b0; cond = '0; op = '0; funct = '0; rd = '0; alu_flags = '0;
        mflags = FLAG_RESET;
        repeat (3) @(posedge clk);
        #1 check_reset("reset_state");
        reset_n = 1'b1;
        mon_en  = 1'b1;

        run_instr(4'hE, 2'b00, 6'b101000, 4'd3, 4'b1111);  // ADD imm, AL
        run_instr(4'hE, 2'b01, 6'b010001, 4'd4, 4'b0000);  // LDR
        run_instr(4'hE, 2'b01, 6'b010000, 4'd5, 4'b0000);  // STR
        run_instr(4'hE, 2'b00, 6'b001001, 4'd1, 4'b0011);  // ADDS -> flags 0011
        run_instr(4'hE, 2'b00, 6'b100001, 4'd2, 4'b1011);  // ANDS -> flags 1011
        run_instr(4'hE, 2'b00, 6'b000101, 4'd6, 4'b0100);  // SUBS -> flags 0100
        run_instr(4'h0, 2'b10, 6'b000000, 4'd0, 4'b0000);  // BEQ taken
        run_instr(4'h1, 2'b10, 6'b000000, 4'd0, 4'b0000);  // BNE not taken
        run_instr(4'hE, 2'b11, 6'b111111, 4'd7, 4'b1111);  // illegal op
        run_instr(4'hE, 2'b00, 6'b110101, 4'd7, 4'b1111);  // unsupported cmd, S=1
        run_instr(4'hE, 2'b01, 6'b000001, 4'd15, 4'b0000); // LDR to PC
        run_instr(4'hE, 2'b00, 6'b111000, 4'd15, 4'b0000); // ORR to PC
        run_instr(4'hF, 2'b00, 6'b101001, 4'd8, 4'b1111);  // cond 1111 never

        run_random(200);

        // STR aborted by reset while in MEMWR.
        cyc_budget = 4;
        abort_mode = 1'b1;
        run_instr(4'hE, 2'b01, 6'b000000, 4'd9, 4'b0000);
        abort_mode = 1'b0;
        cyc_budget = 1 << 30;
        mflags     = FLAG_RESET;
        n_checks++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL abort_queue: %0d entries left, required 0", exp_q.size());
            exp_q.delete();
        end
        reset_n = 1'b1;
        mon_en  = 1'b1;

        run_instr(4'hE, 2'b00, 6'b001001, 4'd2, 4'b1000);
        run_random(100);

        mon_en = 1'b0;
        n_checks++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL final_queue: %0d entries left, required 0", exp_q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
